// File: rtl/sap1_pkg.sv
// sap1_pkg: shared definitions for the SAP-1 controller slice.
//   - opcode_e      : opcode nibble encodings (LDA, ADD, SUB, OUT, HLT)
//   - CW_*          : bit positions inside the 12-bit control word,
//                     MSB first in the order Cp,Ep,nLm,nCE,nLi,nEi,nLa,Ea,Su,Eu,nLb,nLo
//   - CW_INACTIVE   : control word with every strobe deasserted
package sap1_pkg;

    typedef enum logic [3:0] {
        OP_LDA = 4'b0000,
        OP_ADD = 4'b0001,
        OP_SUB = 4'b0010,
        OP_OUT = 4'b1110,
        OP_HLT = 4'b1111
    } opcode_e;

    localparam int unsigned CW_WIDTH = 12;

    localparam int unsigned CW_CP  = 11;
    localparam int unsigned CW_EP  = 10;
    localparam int unsigned CW_NLM = 9;
    localparam int unsigned CW_NCE = 8;
    localparam int unsigned CW_NLI = 7;
    localparam int unsigned CW_NEI = 6;
    localparam int unsigned CW_NLA = 5;
    localparam int unsigned CW_EA  = 4;
    localparam int unsigned CW_SU  = 3;
    localparam int unsigned CW_EU  = 2;
    localparam int unsigned CW_NLB = 1;
    localparam int unsigned CW_NLO = 0;

    // Active-high strobes 0, active-low strobes 1.
    localparam logic [CW_WIDTH-1:0] CW_INACTIVE = 12'b0011_1110_0011;

endpackage

// File: rtl/controller_sequencer_ring_counter.sv
// ring_counter: one-hot rotating T-state counter.
// Ports:
//   clk     : clock, state changes on posedge
//   clr     : synchronous active-high reset, loads state to bit0 (T1)
//   advance : rotate left by one bit on this posedge
//   state   : one-hot ring state, bit0 = T1
module ring_counter #(
    parameter int unsigned LEN = 6
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           advance,
    output logic [LEN-1:0] state
);

    localparam logic [LEN-1:0] FIRST = {{(LEN-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= FIRST;
        end else if (advance) begin
            state <= {state[LEN-2:0], state[LEN-1]};
        end
    end

endmodule

// File: rtl/controller_sequencer.sv
// controller_sequencer: SAP-1 controller/sequencer. Runs a T1..T<RING_LEN>
// one-hot ring and decodes it together with the IR opcode into the 12-bit
// control word (Moore outputs of registered T and HLT).
// Ports:
//   CLK    : clock
//   CLR    : synchronous active-high reset (T=T1, HLT=0, word inactive)
//   IR_OP  : opcode nibble from the instruction register (used in T4..T6)
//   MANUAL, STEP : single-step controls, present only with SAP1_SINGLE_STEP_EN
//   Cp, Ep, nLm, nCE, nLi, nEi, nLa, Ea, Su, Eu, nLb, nLo : control word
//   HLT    : halt flag, freezes the ring until CLR
//   T      : one-hot ring state, bit0 = T1
// Optional feature macro: SAP1_SINGLE_STEP_EN.
module controller_sequencer
    import sap1_pkg::*;
#(
    parameter int unsigned RING_LEN = 6
) (
    input  logic                CLK,
    input  logic                CLR,
    input  logic [3:0]          IR_OP,
`ifdef SAP1_SINGLE_STEP_EN
    input  logic                MANUAL,
    input  logic                STEP,
`endif
    output logic                Cp,
    output logic                Ep,
    output logic                nLm,
    output logic                nCE,
    output logic                nLi,
    output logic                nEi,
    output logic                nLa,
    output logic                Ea,
    output logic                Su,
    output logic                Eu,
    output logic                nLb,
    output logic                nLo,
    output logic                HLT,
    output logic [RING_LEN-1:0] T
);

    logic [RING_LEN-1:0] t_state;
    logic                halted;
    logic                step_ok;
    logic                halt_now;
    logic                advance;
    logic [CW_WIDTH-1:0] cw;

`ifdef SAP1_SINGLE_STEP_EN
    // In manual mode only a STEP cycle counts as a real machine cycle.
    assign step_ok = !MANUAL || STEP;
`else
    assign step_ok = 1'b1;
`endif

    // A HLT opcode halts on the edge closing T4 and that same edge must not
    // rotate the ring, so the ring stays parked on T4.
    assign halt_now = t_state[3] && (IR_OP == OP_HLT) && step_ok && !halted;
    assign advance  = !halted && step_ok && !halt_now;

    ring_counter #(
        .LEN(RING_LEN)
    ) u_ring (
        .clk     (CLK),
        .clr     (CLR),
        .advance (advance),
        .state   (t_state)
    );

    always_ff @(posedge CLK) begin
        if (CLR) begin
            halted <= 1'b0;
        end else if (halt_now) begin
            halted <= 1'b1;
        end
    end

    always_comb begin
        cw = CW_INACTIVE;
        if (!CLR && !halted && step_ok) begin
            if (t_state[0]) begin
                cw[CW_EP]  = 1'b1;
                cw[CW_NLM] = 1'b0;
            end
            if (t_state[1]) begin
                cw[CW_CP] = 1'b1;
            end
            if (t_state[2]) begin
                cw[CW_NCE] = 1'b0;
                cw[CW_NLI] = 1'b0;
            end
            case (IR_OP)
                OP_LDA: begin
                    if (t_state[3]) begin
                        cw[CW_NEI] = 1'b0;
                        cw[CW_NLM] = 1'b0;
                    end
                    if (t_state[4]) begin
                        cw[CW_NCE] = 1'b0;
                        cw[CW_NLA] = 1'b0;
                    end
                end
                OP_ADD, OP_SUB: begin
                    if (t_state[3]) begin
                        cw[CW_NEI] = 1'b0;
                        cw[CW_NLM] = 1'b0;
                    end
                    if (t_state[4]) begin
                        cw[CW_NCE] = 1'b0;
                        cw[CW_NLB] = 1'b0;
                    end
                    if (t_state[5]) begin
                        cw[CW_EU]  = 1'b1;
                        cw[CW_NLA] = 1'b0;
                    end
                    // Su held across the whole execute phase so the
                    // subtractor has settled before Eu drives the bus.
                    if ((IR_OP == OP_SUB) && (|t_state[5:3])) begin
                        cw[CW_SU] = 1'b1;
                    end
                end
                OP_OUT: begin
                    if (t_state[3]) begin
                        cw[CW_EA]  = 1'b1;
                        cw[CW_NLO] = 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign Cp  = cw[CW_CP];
    assign Ep  = cw[CW_EP];
    assign nLm = cw[CW_NLM];
    assign nCE = cw[CW_NCE];
    assign nLi = cw[CW_NLI];
    assign nEi = cw[CW_NEI];
    assign nLa = cw[CW_NLA];
    assign Ea  = cw[CW_EA];
    assign Su  = cw[CW_SU];
    assign Eu  = cw[CW_EU];
    assign nLb = cw[CW_NLB];
    assign nLo = cw[CW_NLO];
    assign HLT = halted;
    assign T   = t_state;

endmodule
